// File: rtl/edf_scheduler.sv
// Earliest-deadline-first grant scheduler for N per-core packet queues.
// One down-counter per queue tracks the remaining relative deadline; the
// eligible queue with the least slack is handed to the serializer.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an eligible queue and a ready serializer
// GRANT   | ready asserted to queue core_id until its delivery pulse
// HOLDOFF | one dead cycle so each grant gives a fresh ready edge
module edf_scheduler #(
  parameter int  NUMBER_OF_QUEUES = 4,
  parameter int  REGISTER_SIZE    = 32,
  localparam int IW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] periods,
  input  logic [NUMBER_OF_QUEUES-1:0]               empty,
  input  logic                                       serializer_ready,
  input  logic                                       queues_to_serializer_valid,
  output logic                                       scheduler_to_queues_ready,
  output logic [IW-1:0]                              core_id,
  output logic [NUMBER_OF_QUEUES-1:0]               deadline_miss,
  output logic                                       busy
);

  localparam int N = NUMBER_OF_QUEUES;
  localparam int R = REGISTER_SIZE;
  localparam logic [R-1:0] ONE = {{(R-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

  state_t         state_q;
  logic [R-1:0]   period_w [N];
  logic [R-1:0]   d_q [N];
  logic [R-1:0]   d_d [N];
  logic [N-1:0]   eligible;
  logic [N-1:0]   reload;
  logic [N-1:0]   miss_q;
  logic [N-1:0]   miss_d;
  logic [IW-1:0]  sel;
  logic [IW-1:0]  core_id_q;
  logic [R-1:0]   best;
  logic           any_eligible;
  logic           ready_q;
  logic           busy_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      period_w[i] = periods[i*R +: R];
      eligible[i] = !empty[i] && (period_w[i] != '0);
    end
  end

  // Strict less-than keeps the lowest index on equal deadlines.
  always_comb begin
    sel          = '0;
    best         = '0;
    any_eligible = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (!any_eligible || d_q[i] < best)) begin
        any_eligible = 1'b1;
        best         = d_q[i];
        sel          = IW'(i);
      end
    end
  end

  // A delivery pulse reloads the served counter and clears its miss flag,
  // taking priority over both the decrement and a same-cycle miss set.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      reload[i] = (state_q == GRANT) && queues_to_serializer_valid &&
                  (core_id_q == IW'(i));
      if (reload[i]) begin
        d_d[i] = period_w[i];
      end else if (d_q[i] == '0) begin
        d_d[i] = '0;
      end else begin
        d_d[i] = d_q[i] - ONE;
      end
      if (reload[i]) begin
        miss_d[i] = 1'b0;
      end else if ((d_q[i] == '0) && eligible[i]) begin
        miss_d[i] = 1'b1;
      end else begin
        miss_d[i] = miss_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        d_q[i] <= period_w[i];
      end
      miss_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        d_q[i] <= d_d[i];
      end
      miss_q <= miss_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      core_id_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_eligible && serializer_ready) begin
            state_q   <= GRANT;
            core_id_q <= sel;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        GRANT: begin
          if (queues_to_serializer_valid) begin
            state_q <= HOLDOFF;
            ready_q <= 1'b0;
          end
        end
        HOLDOFF: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign scheduler_to_queues_ready = ready_q;
  assign core_id                   = core_id_q;
  assign deadline_miss             = miss_q;
  assign busy                      = busy_q;

endmodule

// File: tb/tb_edf_scheduler.sv
// Bench for edf_scheduler: directed scenarios plus randomized traffic, all
// compared against an integer-level EDF reference model.
module tb_edf_scheduler;
  localparam int N = 4;
  localparam int R = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*R-1:0] periods;
  logic [N-1:0]   empty;
  logic           serializer_ready;
  logic           valid;
  logic           ready;
  logic [1:0]     core_id;
  logic [N-1:0]   miss;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;
  int p[N];

  // reference model state
  int md[N];
  int m_phase;   // 0 waiting, 1 granting, 2 dead cycle
  int m_core;
  bit m_miss[N];

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) periods[i*R +: R] = R'(p[i]);
  end

  edf_scheduler #(.NUMBER_OF_QUEUES(N), .REGISTER_SIZE(R)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .periods                    (periods),
    .empty                      (empty),
    .serializer_ready           (serializer_ready),
    .queues_to_serializer_valid (valid),
    .scheduler_to_queues_ready  (ready),
    .core_id                    (core_id),
    .deadline_miss              (miss),
    .busy                       (busy)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // What the next clock edge must do, from the current inputs.
  task automatic model_step();
    bit elig[N];
    int pick;
    int served;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        md[i] = p[i];
        m_miss[i] = 0;
      end
      m_phase = 0;
      m_core  = 0;
      return;
    end
    pick = -1;
    for (int i = 0; i < N; i++) begin
      elig[i] = !empty[i] && p[i] != 0;
      if (elig[i] && (pick < 0 || md[i] < md[pick])) pick = i;
    end
    served = (m_phase == 1 && valid) ? m_core : -1;
    for (int i = 0; i < N; i++) begin
      if (i == served) m_miss[i] = 0;
      else if (md[i] == 0 && elig[i]) m_miss[i] = 1;
      if (i == served) md[i] = p[i];
      else if (md[i] > 0) md[i] = md[i] - 1;
    end
    case (m_phase)
      0: if (pick >= 0 && serializer_ready) begin
           m_phase = 1;
           m_core  = pick;
         end
      1: if (valid) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    check("ready", ready, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("core_id", core_id, m_core);
    for (int i = 0; i < N; i++) begin
      check($sformatf("miss[%0d]", i), miss[i], m_miss[i]);
      check($sformatf("D[%0d]", i), dut.d_q[i], md[i]);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic set_p(input int a, input int b, input int c, input int d);
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
  endtask

  initial begin
    int order[$];
    int exp_order[4];
    int c;
    reset = 1'b1;
    empty = '1;
    serializer_ready = 1'b0;
    valid = 1'b0;
    set_p(10, 10, 10, 10);

    // single-queue service and ready spacing
    empty = 4'b1110;
    serializer_ready = 1'b1;
    do_reset();
    check("sq_idle_after_reset", ready, 0);
    cycle();
    check("sq_ready_rise", ready, 1);
    check("sq_core", core_id, 0);
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    check("sq_ready_one_cycle", ready, 0);
    check("sq_reload", dut.d_q[0], 10);
    cycle();
    check("sq_gap2", ready, 0);
    cycle();
    check("sq_regrant", ready, 1);
    valid = 1'b1;
    cycle();
    valid = 1'b0;

    // EDF order with one packet per queue
    set_p(40, 8, 20, 30);
    empty = 4'b0000;
    do_reset();
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      if (ready) begin
        order.push_back(int'(core_id));
        empty[core_id] = 1'b1;
        valid = 1'b1;
      end
      cycle();
      valid = 1'b0;
    end
    exp_order = '{1, 2, 3, 0};
    check("edf_grant_count", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++)
      check($sformatf("edf_order[%0d]", k), order[k], exp_order[k]);

    // tie break
    set_p(5, 5, 5, 5);
    empty = 4'b0000;
    do_reset();
    cycle();
    check("tie_ready", ready, 1);
    check("tie_core", core_id, 0);
    valid = 1'b1;
    cycle();
    valid = 1'b0;

    // deadline miss and saturation
    set_p(10, 10, 3, 10);
    empty = 4'b1011;
    serializer_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    check("sat_D2", dut.d_q[2], 0);
    check("sat_miss2", miss[2], 1);
    serializer_ready = 1'b1;
    cycle();
    check("sat_grant_core", core_id, 2);
    check("sat_grant_ready", ready, 1);
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    check("sat_miss2_clear", miss[2], 0);
    check("sat_D2_reload", dut.d_q[2], 3);

    // stall in GRANT then reset
    set_p(10, 10, 10, 10);
    empty = 4'b0000;
    do_reset();
    cycle();
    c = int'(core_id);
    for (int k = 0; k < 20; k++) begin
      empty = 4'($urandom);
      serializer_ready = 1'($urandom);
      cycle();
      check("stall_ready", ready, 1);
      check("stall_core", core_id, c);
    end
    set_p(7, 9, 11, 13);
    do_reset();
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < N; i++) check($sformatf("rst_D[%0d]", i), dut.d_q[i], p[i]);

    // disabled queue
    set_p(10, 10, 10, 0);
    empty = 4'b0111;
    serializer_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      valid = 1'($urandom);
      cycle();
      check("dis_no_grant", ready, 0);
      check("dis_no_miss", miss[3], 0);
    end
    valid = 1'b0;

    // randomized traffic
    for (int i = 0; i < N; i++) p[i] = $urandom_range(0, 12);
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      empty = 4'($urandom);
      serializer_ready = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) p[$urandom_range(0, N-1)] = $urandom_range(0, 12);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
